// File: rtl/pc_next_unit_if.sv
// Control and status bundle for pc_next_unit.
// The datapath or bench drives through master; the PC stage connects to slave.
interface pc_next_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic              stall;
    logic              branch;
    logic              zero;
    logic [31:0]       branch_offset;
    logic              jump;
    logic [25:0]       jump_index;
    logic              jr;
    logic [31:0]       jr_target;
    logic              halt_req;
    logic              resume;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic [1:0]        state;
    logic [31:0]       fault_addr;
    logic [CNT_W-1:0]  redirect_count;

    modport master (
        output stall, branch, zero, branch_offset, jump, jump_index, jr, jr_target,
               halt_req, resume,
        input  pc, pc_plus4, state, fault_addr, redirect_count
    );

    modport slave (
        input  stall, branch, zero, branch_offset, jump, jump_index, jr, jr_target,
               halt_req, resume,
        output pc, pc_plus4, state, fault_addr, redirect_count
    );
endinterface

// File: rtl/pc_next_unit.sv
// MIPS program-counter stage: next-PC select, stall, halt/resume, redirect counter.
// Define PC_ALIGN_CHECK_EN to trap misaligned targets into a sticky FAULT state.
module pc_next_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter int unsigned CNT_W        = 16
) (
    input logic          clk,
    input logic          rst_n,
    pc_next_unit_if.slave bus
);
    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StHalted = 2'b01,
        StFault  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      fault_addr_q, fault_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] load_val;
    logic        redirect;
    logic        misaligned;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        target   = pc_plus4;
        redirect = 1'b1;
        if (bus.jr) begin
            target = bus.jr_target;
        end else if (bus.jump) begin
            target = {pc_plus4[31:28], bus.jump_index, 2'b00};
        end else if (bus.branch && bus.zero) begin
            target = pc_plus4 + bus.branch_offset;
        end else begin
            redirect = 1'b0;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned = |target[1:0];
    assign load_val   = target;
`else
    // Without the check, low bits are simply dropped so pc stays word-aligned.
    assign misaligned = 1'b0;
    assign load_val   = target & 32'hFFFF_FFFC;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_addr_d = fault_addr_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            StRun: begin
                if (bus.halt_req) begin
                    state_d = StHalted;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (misaligned) begin
                    state_d      = StFault;
                    fault_addr_d = target;
                end else begin
                    pc_d = load_val;
                    if (redirect) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StHalted: begin
                if (bus.resume && !bus.halt_req) begin
                    state_d = StRun;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StRun;
            pc_q         <= RESET_VECTOR;
            fault_addr_q <= 32'h0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_addr_q <= fault_addr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_plus4;
    assign bus.state          = state_q;
    assign bus.fault_addr     = fault_addr_q;
    assign bus.redirect_count = cnt_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit; a second CNT_W=2 instance shares stimulus to show wrap.
module tb_pc_next_unit;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pc_next_unit_if #(.CNT_W(16)) bus ();
    pc_next_unit_if #(.CNT_W(2))  bus_s ();

    pc_next_unit #(.RESET_VECTOR(32'h0040_0000), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pc_next_unit #(.RESET_VECTOR(32'h0040_0000), .CNT_W(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    int tests = 0;
    int fails = 0;
    int unsigned exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] exp_pc, input logic [1:0] exp_st);
        chk({tag, " pc"}, bus.pc, exp_pc);
        chk({tag, " state"}, {30'b0, bus.state}, {30'b0, exp_st});
        chk({tag, " cnt"}, {16'b0, bus.redirect_count}, exp_cnt);
        chk({tag, " cnt_small"}, {30'b0, bus_s.redirect_count}, exp_cnt & 32'd3);
    endtask

    task automatic drive(input logic st, input logic br, input logic z, input logic [31:0] off,
                         input logic jp, input logic [25:0] idx, input logic r,
                         input logic [31:0] rt, input logic h, input logic res);
        bus.stall = st;       bus_s.stall = st;
        bus.branch = br;      bus_s.branch = br;
        bus.zero = z;         bus_s.zero = z;
        bus.branch_offset = off; bus_s.branch_offset = off;
        bus.jump = jp;        bus_s.jump = jp;
        bus.jump_index = idx; bus_s.jump_index = idx;
        bus.jr = r;           bus_s.jr = r;
        bus.jr_target = rt;   bus_s.jr_target = rt;
        bus.halt_req = h;     bus_s.halt_req = h;
        bus.resume = res;     bus_s.resume = res;
    endtask

    task automatic idle();
        drive(0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        chk_pc("reset", 32'h0040_0000, 2'b00);
        chk("reset fault_addr", bus.fault_addr, 32'h0);
        rst_n = 1'b1;
        chk("reset pc_plus4", bus.pc_plus4, 32'h0040_0004);
        step();
        chk_pc("idle1", 32'h0040_0004, 2'b00);
        step();
        chk_pc("idle2", 32'h0040_0008, 2'b00);
        step();
        step();
        chk_pc("idle4", 32'h0040_0010, 2'b00);

        // Taken backward branch: 0x400014 - 8.
        drive(0, 1, 1, 32'hFFFF_FFF8, 0, 26'h0, 0, 32'h0, 0, 0);
        step();
        exp_cnt = 1;
        chk_pc("br taken", 32'h0040_000C, 2'b00);
        idle();
        step();
        drive(0, 1, 0, 32'hFFFF_FFF8, 0, 26'h0, 0, 32'h0, 0, 0);
        step();
        chk_pc("br not taken", 32'h0040_0014, 2'b00);

        drive(0, 0, 0, 32'h0, 1, 26'h0000_3FF, 1, 32'h0040_0100, 0, 0);
        step();
        exp_cnt = 2;
        chk_pc("jr prio", 32'h0040_0100, 2'b00);
        drive(0, 0, 0, 32'h0, 0, 26'h0, 1, 32'h1040_0000, 0, 0);
        step();
        exp_cnt = 3;
        drive(0, 0, 0, 32'h0, 1, 26'h000_0010, 0, 32'h0, 0, 0);
        step();
        exp_cnt = 4;
        chk_pc("jump", 32'h1000_0040, 2'b00);

        drive(1, 1, 1, 32'h0000_0100, 0, 26'h0, 0, 32'h0, 0, 0);
        step();
        step();
        chk_pc("stall", 32'h1000_0040, 2'b00);
        drive(1, 1, 1, 32'h0000_0100, 0, 26'h0, 0, 32'h0, 1, 0);
        step();
        chk_pc("halt in stall", 32'h1000_0040, 2'b01);
        idle();
        step();
        chk_pc("halted hold", 32'h1000_0040, 2'b01);
        drive(0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0, 1, 1);
        step();
        chk_pc("halt+resume", 32'h1000_0040, 2'b01);
        drive(0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0, 0, 1);
        step();
        chk_pc("resume", 32'h1000_0040, 2'b00);
        idle();
        step();
        chk_pc("after resume", 32'h1000_0044, 2'b00);

        drive(0, 0, 0, 32'h0, 0, 26'h0, 1, 32'h0000_2000, 1, 0);
        step();
        chk_pc("halt beats jr", 32'h1000_0044, 2'b01);
        drive(0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0, 0, 1);
        step();
        chk_pc("resume2", 32'h1000_0044, 2'b00);

        drive(0, 0, 0, 32'h0, 0, 26'h0, 1, 32'h0040_0102, 0, 0);
        step();
`ifdef PC_ALIGN_CHECK_EN
        chk_pc("misalign fault", 32'h1000_0044, 2'b10);
        chk("fault_addr", bus.fault_addr, 32'h0040_0102);
        drive(0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0, 0, 1);
        step();
        chk_pc("fault sticky", 32'h1000_0044, 2'b10);
        chk("fault_addr held", bus.fault_addr, 32'h0040_0102);
`else
        exp_cnt = 5;
        chk_pc("misalign masked", 32'h0040_0100, 2'b00);
        chk("fault_addr zero", bus.fault_addr, 32'h0);
`endif
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_cnt = 0;
        chk_pc("mid reset", 32'h0040_0000, 2'b00);
        chk("mid reset fault_addr", bus.fault_addr, 32'h0);

        drive(0, 0, 0, 32'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 0, 0);
        step();
        exp_cnt = 1;
        chk_pc("jr top", 32'hFFFF_FFFC, 2'b00);
        chk("pc_plus4 wrap", bus.pc_plus4, 32'h0);
        idle();
        step();
        chk_pc("pc wrap", 32'h0000_0000, 2'b00);
        // Three jumps bring the total to 4 so the 2-bit counter rolls over to 0.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 32'h0, 1, 26'h000_0003, 0, 32'h0, 0, 0);
            step();
            exp_cnt++;
        end
        chk_pc("cnt wrap", 32'h0000_000C, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Sequential program-counter stage of the MIPS datapath. Holds the PC register and selects the next PC from sequential (PC+4), conditional branch (PC+4 plus the word-aligned offset from the shift-left-by-2 stage), J-type jump, and register jump (`jr`). Supports stall, halt/resume, and an optional misaligned-target fault. Drives instruction-memory address and the PC+4 value used for `jal` link writes.

## Interface
Parameters:
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset.
- CNT_W, 16, width of the redirect counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- stall  input  1  hold PC this cycle; state machine still evaluates.
- branch  input  1  current instruction is a conditional branch.
- zero  input  1  ALU zero flag; branch taken when branch & zero.
- branch_offset  input  32  sign-extended immediate already shifted left by 2.
- jump  input  1  J/JAL instruction.
- jump_index  input  26  instr[25:0].
- jr  input  1  register jump.
- jr_target  input  32  rs value.
- halt_req  input  1  request halt.
- resume  input  1  leave HALTED.
- pc  output  32  current PC (registered).
- pc_plus4  output  32  pc + 4 (combinational from pc).
- state  output  2  00 RUN, 01 HALTED, 10 FAULT.
- fault_addr  output  32  offending target captured on fault.
- redirect_count  output  CNT_W  accepted non-sequential updates.

## Operation
- Target selection, priority high to low: jr -> jr_target; jump -> {pc_plus4[31:28], jump_index, 2'b00}; branch & zero -> pc_plus4 + branch_offset; else pc_plus4.
- All additions 32-bit modulo 2^32; 0xFFFF_FFFC + 4 = 0x0000_0000; negative offsets wrap by two's complement.
- RUN: if halt_req -> HALTED, pc held (halt beats redirect and stall). Else if stall -> pc held, no count. Else if target misaligned (macro enabled) -> FAULT, pc held, fault_addr <= target. Else pc <= target; redirect_count increments if target source was jr, jump or taken branch.
- HALTED: pc held; resume -> RUN next cycle; halt_req & resume together -> stay HALTED.
- FAULT: sticky; pc, fault_addr held; exits only via reset. resume ignored.
- redirect_count wraps from all-ones to 0.
- Reset values: pc = RESET_VECTOR, state = RUN, fault_addr = 0, redirect_count = 0.

## Timing
- Single-cycle: target computed combinationally from current inputs; pc updates on the next rising edge. Redirect visible on pc exactly one cycle after the instruction's control inputs are presented.
- pc_plus4 changes in the same cycle as pc (combinational).
- state transitions take effect on the clock edge; halt_req sampled at edge t -> state = HALTED after t, pc equals value before t.
- Reset mid-operation (rst_n low at an edge) overrides everything including FAULT and stall; outputs at reset values after that edge.
- Inputs other than halt_req/resume are don't-care outside RUN.

## Configuration
- PC_ALIGN_CHECK_EN defined: target[1:0] != 0 causes RUN -> FAULT as above.
- Undefined: target[1:0] forced to 2'b00 before loading pc; FAULT state unreachable, fault_addr stays 0.

## Test plan
- Reset with RESET_VECTOR default, 3 idle cycles -> pc 0x0040_0000, 0x0040_0004, 0x0040_0008; count 0.
- pc=0x0040_0010, branch=1, zero=1, offset=0xFFFF_FFF8 -> pc=0x0040_000C, count=1; same with zero=0 -> pc=0x0040_0014, count unchanged.
- jr=1, jump=1, jr_target=0x0040_0100 simultaneously -> pc=0x0040_0100 (jr priority); jump alone, pc=0x1040_0000, index=0x0000010 -> pc=0x1000_0040.
- stall=1 with branch taken for 2 cycles -> pc held, count held; halt_req during stall -> HALTED; resume -> RUN, pc advances next cycle.
- With PC_ALIGN_CHECK_EN: jr_target=0x0040_0102 -> state=FAULT, fault_addr=0x0040_0102, pc held through resume; rst_n low one edge -> RUN, pc=0x0040_0000. Without macro: pc=0x0040_0100.
- pc forced to 0xFFFF_FFFC via jr, then idle -> pc=0x0000_0000; CNT_W=2, 4 redirects -> count wraps to 0.
